// File: rtl/apb_slave_regfile.sv
// APB3 completer: fifteen R/W registers, a read-only transfer counter at 0x3C, fixed wait states.
// Optional error response on unmapped / read-only writes when APB_SLV_PSLVERR_EN is defined.
module apb_slave_regfile #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] RESET_VAL   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  paddr,
  input  logic        pwrite,
  input  logic        psel,
  input  logic        penable,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready
`ifdef APB_SLV_PSLVERR_EN
  ,
  output logic        pslverr
`endif
);

  // Handshake: a transfer starts with a SETUP cycle (psel && !penable); pready is
  // raised for exactly one ACCESS cycle and the transfer completes at the end of it.
  // Dropping psel before that cycle ends aborts the transfer with no side effects.
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  state_t      state;
  logic [3:0]  wcnt;
  logic [5:0]  idx_q;
  logic        wr_q;
  logic [31:0] regs [0:14];
  logic [31:0] xfer_cnt;

  logic        setup;
  logic        enter_ready;
  logic        complete;
  logic [5:0]  cur_idx;
  logic        cur_wr;
  logic [31:0] rd_val;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^paddr[1:0];
  assign setup = psel && !penable;

  // With zero wait states READY is entered on the SETUP edge, before idx_q/wr_q are loaded.
  assign cur_idx = (state == S_IDLE) ? paddr[7:2] : idx_q;
  assign cur_wr  = (state == S_IDLE) ? pwrite : wr_q;

  assign enter_ready = ((state == S_IDLE) && setup && (WAIT_CYCLES == 0)) ||
                       ((state == S_WAIT) && psel && penable && (wcnt == 4'd1));
  assign complete    = (state == S_READY) && psel && penable;

  always_comb begin
    rd_val = 32'h0;
    if (cur_idx < 6'd15)       rd_val = regs[cur_idx[3:0]];
    else if (cur_idx == 6'd15) rd_val = xfer_cnt;
  end

`ifdef APB_SLV_PSLVERR_EN
  logic err_cond;
  assign err_cond = (cur_idx > 6'd15) || ((cur_idx == 6'd15) && cur_wr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pslverr <= 1'b0;
    else     pslverr <= enter_ready && err_cond;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wcnt     <= 4'd0;
      idx_q    <= 6'd0;
      wr_q     <= 1'b0;
      prdata   <= 32'h0;
      pready   <= 1'b0;
      xfer_cnt <= 32'h0;
      for (int i = 0; i < 15; i++) regs[i] <= RESET_VAL;
    end else begin
      pready <= enter_ready;
      prdata <= enter_ready ? rd_val : 32'h0;
      case (state)
        S_IDLE: begin
          if (setup) begin
            idx_q <= paddr[7:2];
            wr_q  <= pwrite;
            wcnt  <= 4'(WAIT_CYCLES);
            state <= (WAIT_CYCLES == 0) ? S_READY : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!psel) begin
            state <= S_IDLE;
          end else if (penable) begin
            if (wcnt == 4'd1) state <= S_READY;
            else              wcnt  <= wcnt - 4'd1;
          end
        end
        S_READY: begin
          state <= S_IDLE;
          if (complete) begin
            xfer_cnt <= xfer_cnt + 32'd1;
            if (wr_q && (idx_q < 6'd15)) regs[idx_q[3:0]] <= pwdata;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: three builds side by side (0, 2 and 15 wait states)
// sharing one APB bus, selected one at a time.
module tb_apb_slave_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  paddr = 8'h0;
  logic        pwrite = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic [31:0] pwdata = 32'h0;
  int          cur = 1;

  logic        psel0, psel1, psel2;
  logic [31:0] prdata0, prdata1, prdata2;
  logic        pready0, pready1, pready2;
  logic        err0, err1, err2;
  logic [31:0] c_prdata;
  logic        c_pready, c_err;

  int          nvec = 0;
  int          nfail = 0;
  int          lat [3] = '{1, 3, 16};
  logic [31:0] exp_cnt [3];
  logic [31:0] pat [15];
  logic [31:0] rd;
  logic [31:0] saved;

  always #5 clk = ~clk;

  assign psel0 = psel && (cur == 0);
  assign psel1 = psel && (cur == 1);
  assign psel2 = psel && (cur == 2);

`ifndef APB_SLV_PSLVERR_EN
  assign err0 = 1'b0;
  assign err1 = 1'b0;
  assign err2 = 1'b0;
`endif

  apb_slave_regfile #(.WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .paddr(paddr), .pwrite(pwrite), .psel(psel0), .penable(penable),
    .pwdata(pwdata), .prdata(prdata0), .pready(pready0)
`ifdef APB_SLV_PSLVERR_EN
    , .pslverr(err0)
`endif
  );

  apb_slave_regfile #(.WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst(rst), .paddr(paddr), .pwrite(pwrite), .psel(psel1), .penable(penable),
    .pwdata(pwdata), .prdata(prdata1), .pready(pready1)
`ifdef APB_SLV_PSLVERR_EN
    , .pslverr(err1)
`endif
  );

  apb_slave_regfile #(.WAIT_CYCLES(15), .RESET_VAL(32'hCAFE0000)) dut_w15 (
    .clk(clk), .rst(rst), .paddr(paddr), .pwrite(pwrite), .psel(psel2), .penable(penable),
    .pwdata(pwdata), .prdata(prdata2), .pready(pready2)
`ifdef APB_SLV_PSLVERR_EN
    , .pslverr(err2)
`endif
  );

  always_comb begin
    c_prdata = prdata1;
    c_pready = pready1;
    c_err    = err1;
    case (cur)
      0: begin c_prdata = prdata0; c_pready = pready0; c_err = err0; end
      2: begin c_prdata = prdata2; c_pready = pready2; c_err = err2; end
      default: ;
    endcase
  end

  // Driver: called just after a rising edge; returns just after a rising edge.
  task automatic xfer(input int inst, input logic wr, input logic [7:0] addr,
                      input logic [31:0] wdata, input logic exp_err, input bit b2b,
                      output logic [31:0] rdata);
    int  rcyc;
    bit  done;
    logic got_err;
    rdata = 32'h0;
    rcyc = -1;
    done = 0;
    got_err = 1'b0;
    cur = inst; paddr = addr; pwrite = wr; pwdata = wdata; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    nvec++;
    if (c_pready !== 1'b0) begin nfail++; $display("FAIL setup_pready: got %b expected 0", c_pready); end
    @(posedge clk); #1 penable = 1'b1;
    for (int n = 1; n <= 40 && !done; n++) begin
      @(negedge clk);
      if (c_pready === 1'b1) begin
        rcyc = n; rdata = c_prdata; got_err = c_err; done = 1;
      end else begin
        nvec++;
        if (c_prdata !== 32'h0) begin nfail++; $display("FAIL wait_prdata: got %h expected 0", c_prdata); end
        @(posedge clk); #1;
      end
    end
    nvec++;
    if (rcyc != lat[inst]) begin
      nfail++; $display("FAIL latency inst%0d addr %h: got %0d expected %0d", inst, addr, rcyc, lat[inst]);
    end
`ifdef APB_SLV_PSLVERR_EN
    nvec++;
    if (got_err !== exp_err) begin nfail++; $display("FAIL pslverr addr %h: got %b expected %b", addr, got_err, exp_err); end
`else
    if (exp_err === 1'bx) $display("note: unexpected x in exp_err %b", got_err);
`endif
    if (done) exp_cnt[inst] = exp_cnt[inst] + 32'd1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    if (!b2b) begin
      @(negedge clk);
      nvec++;
      if (c_pready !== 1'b0) begin nfail++; $display("FAIL single_pulse: got %b expected 0", c_pready); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nvec++;
    if ({pready0, pready1, pready2} !== 3'b000) begin nfail++; $display("FAIL rst_pready: got %b expected 000", {pready0, pready1, pready2}); end
    nvec++;
    if (prdata1 !== 32'h0) begin nfail++; $display("FAIL rst_prdata: got %h expected 0", prdata1); end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 32'h0;
    xfer(1, 1'b0, 8'h04, 32'h0, 1'b0, 0, rd);
    nvec++;
    if (rd !== 32'h0) begin nfail++; $display("FAIL rd_04_after_reset: got %h expected 0", rd); end
  endtask

  task automatic test_write_readback();
    xfer(1, 1'b1, 8'h08, 32'hDEADBEEF, 1'b0, 0, rd);
    xfer(1, 1'b0, 8'h08, 32'h0, 1'b0, 0, rd);
    nvec++;
    if (rd !== 32'hDEADBEEF) begin nfail++; $display("FAIL rd_08: got %h expected deadbeef", rd); end
    xfer(1, 1'b0, 8'h0B, 32'h0, 1'b0, 0, rd);
    nvec++;
    if (rd !== 32'hDEADBEEF) begin nfail++; $display("FAIL rd_0b_lsbs: got %h expected deadbeef", rd); end
    saved = exp_cnt[1];
    xfer(1, 1'b0, 8'h3C, 32'h0, 1'b0, 0, rd);
    nvec++;
    if (rd !== saved) begin nfail++; $display("FAIL xfer_cnt: got %h expected %h", rd, saved); end
    for (int i = 0; i < 15; i++) begin
      pat[i] = (32'h10000001 * (i + 1)) ^ 32'hF0F05A5A;
      xfer(1, 1'b1, 8'(i * 4), pat[i], 1'b0, 0, rd);
    end
    for (int i = 0; i < 15; i++) begin
      xfer(1, 1'b0, 8'(i * 4), 32'h0, 1'b0, 0, rd);
      nvec++;
      if (rd !== pat[i]) begin nfail++; $display("FAIL regfile[%0d]: got %h expected %h", i, rd, pat[i]); end
    end
  endtask

  task automatic test_unmapped();
    xfer(1, 1'b1, 8'h40, 32'h12345678, 1'b1, 0, rd);
    xfer(1, 1'b1, 8'h3C, 32'h12345678, 1'b1, 0, rd);
    xfer(1, 1'b0, 8'h40, 32'h0, 1'b1, 0, rd);
    nvec++;
    if (rd !== 32'h0) begin nfail++; $display("FAIL rd_40: got %h expected 0", rd); end
    xfer(1, 1'b0, 8'hFC, 32'h0, 1'b1, 0, rd);
    nvec++;
    if (rd !== 32'h0) begin nfail++; $display("FAIL rd_fc: got %h expected 0", rd); end
    saved = exp_cnt[1];
    xfer(1, 1'b0, 8'h3C, 32'h0, 1'b0, 0, rd);
    nvec++;
    if (rd !== saved) begin nfail++; $display("FAIL cnt_after_ro_write: got %h expected %h", rd, saved); end
  endtask

  task automatic test_abort();
    saved = exp_cnt[1];
    cur = 1; paddr = 8'h10; pwrite = 1'b1; pwdata = 32'hA5A5A5A5; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      nvec++;
      if (c_pready !== 1'b0 || c_prdata !== 32'h0) begin
        nfail++; $display("FAIL abort_idle: got pready %b prdata %h expected 0/0", c_pready, c_prdata);
      end
    end
    @(posedge clk); #1;
    xfer(1, 1'b0, 8'h10, 32'h0, 1'b0, 0, rd);
    nvec++;
    if (rd !== pat[4]) begin nfail++; $display("FAIL abort_reg10: got %h expected %h", rd, pat[4]); end
    xfer(1, 1'b0, 8'h3C, 32'h0, 1'b0, 0, rd);
    nvec++;
    if (rd !== saved + 32'd1) begin nfail++; $display("FAIL abort_cnt: got %h expected %h", rd, saved + 32'd1); end
  endtask

  task automatic test_back_to_back();
    xfer(1, 1'b1, 8'h14, 32'h0BADF00D, 1'b0, 1, rd);
    xfer(1, 1'b0, 8'h14, 32'h0, 1'b0, 1, rd);
    nvec++;
    if (rd !== 32'h0BADF00D) begin nfail++; $display("FAIL b2b_rd14: got %h expected 0badf00d", rd); end
    saved = exp_cnt[1];
    xfer(1, 1'b0, 8'h3C, 32'h0, 1'b0, 0, rd);
    nvec++;
    if (rd !== saved) begin nfail++; $display("FAIL b2b_cnt: got %h expected %h", rd, saved); end
  endtask

  task automatic test_reset_mid();
    xfer(1, 1'b1, 8'h0C, 32'h11112222, 1'b0, 0, rd);
    // Read up to its READY cycle, then reset while prdata is live.
    cur = 1; paddr = 8'h0C; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    repeat (3) @(negedge clk);
    nvec++;
    if (c_pready !== 1'b1 || c_prdata !== 32'h11112222) begin
      nfail++; $display("FAIL pre_reset_ready: got %b/%h expected 1/11112222", c_pready, c_prdata);
    end
    rst = 1'b1;
    #1;
    nvec++;
    if (c_pready !== 1'b0 || c_prdata !== 32'h0) begin
      nfail++; $display("FAIL async_reset_drop: got %b/%h expected 0/0", c_pready, c_prdata);
    end
    @(posedge clk); #1 rst = 1'b0; psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 32'h0;
    // Write interrupted by reset in its WAIT phase.
    xfer(1, 1'b1, 8'h0C, 32'h55556666, 1'b0, 0, rd);
    cur = 1; paddr = 8'h0C; pwrite = 1'b1; pwdata = 32'h33334444; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk) rst = 1'b1;
    #1;
    nvec++;
    if (c_pready !== 1'b0 || c_prdata !== 32'h0) begin
      nfail++; $display("FAIL wait_reset: got %b/%h expected 0/0", c_pready, c_prdata);
    end
    @(posedge clk); #1 rst = 1'b0; psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 32'h0;
    xfer(1, 1'b0, 8'h0C, 32'h0, 1'b0, 0, rd);
    nvec++;
    if (rd !== 32'h0) begin nfail++; $display("FAIL reg0c_after_reset: got %h expected 0", rd); end
    xfer(1, 1'b0, 8'h3C, 32'h0, 1'b0, 0, rd);
    nvec++;
    if (rd !== 32'h1) begin nfail++; $display("FAIL cnt_after_reset: got %h expected 1", rd); end
  endtask

  task automatic test_boundaries();
    xfer(0, 1'b0, 8'h00, 32'h0, 1'b0, 0, rd);
    nvec++;
    if (rd !== 32'h0) begin nfail++; $display("FAIL w0_rd00: got %h expected 0", rd); end
    xfer(0, 1'b1, 8'h38, 32'h87654321, 1'b0, 1, rd);
    xfer(0, 1'b0, 8'h38, 32'h0, 1'b0, 0, rd);
    nvec++;
    if (rd !== 32'h87654321) begin nfail++; $display("FAIL w0_rd38: got %h expected 87654321", rd); end
    xfer(2, 1'b0, 8'h00, 32'h0, 1'b0, 0, rd);
    nvec++;
    if (rd !== 32'hCAFE0000) begin nfail++; $display("FAIL w15_resetval: got %h expected cafe0000", rd); end
    xfer(2, 1'b1, 8'h04, 32'h55AA55AA, 1'b0, 0, rd);
    xfer(2, 1'b0, 8'h04, 32'h0, 1'b0, 0, rd);
    nvec++;
    if (rd !== 32'h55AA55AA) begin nfail++; $display("FAIL w15_rd04: got %h expected 55aa55aa", rd); end
    xfer(2, 1'b0, 8'h3C, 32'h0, 1'b0, 0, rd);
    nvec++;
    if (rd !== 32'h3) begin nfail++; $display("FAIL w15_cnt: got %h expected 3", rd); end
    @(negedge clk);
    force dut_w2.xfer_cnt = 32'hFFFFFFFF;
    @(posedge clk); #1;
    release dut_w2.xfer_cnt;
    xfer(1, 1'b0, 8'h3C, 32'h0, 1'b0, 0, rd);
    nvec++;
    if (rd !== 32'hFFFFFFFF) begin nfail++; $display("FAIL cnt_preload: got %h expected ffffffff", rd); end
    xfer(1, 1'b0, 8'h3C, 32'h0, 1'b0, 0, rd);
    nvec++;
    if (rd !== 32'h0) begin nfail++; $display("FAIL cnt_wrap: got %h expected 0", rd); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) exp_cnt[i] = 32'h0;
    for (int i = 0; i < 15; i++) pat[i] = 32'h0;
    @(posedge clk); #1;
    test_reset();
    test_write_readback();
    test_unmapped();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_boundaries();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
